// File: rtl/tick_gen_pkg.sv
// rtl/tick_gen_pkg.sv - shared defaults, mode enum and channel state for multi_tick_gen
package tick_gen_pkg;

  localparam int unsigned CNT_W_DEF = 32;
  localparam logic [CNT_W_DEF-1:0] DEFAULT_DIV_DEF = 32'd50_000_000;

  typedef enum logic {
    MODE_PERIODIC = 1'b0,
    MODE_ONESHOT  = 1'b1
  } mode_e;

  typedef struct packed {
    mode_e mode;
    logic  armed;
  } ch_state_t;

  localparam ch_state_t CH_STATE_RST = '{mode: MODE_PERIODIC, armed: 1'b1};

endpackage

// File: rtl/tick_gen_channel.sv
// rtl/tick_gen_channel.sv - one divide-by-N tick channel (periodic or one-shot)
// Optional square-wave output under MULTI_TICK_GEN_SQ_EN.
module tick_gen_channel
  import tick_gen_pkg::*;
#(
  parameter int unsigned      CNT_W       = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(DEFAULT_DIV_DEF)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ch_en,
  input  logic             load,
  input  logic [CNT_W-1:0] divisor,
  input  logic             oneshot,
`ifdef MULTI_TICK_GEN_SQ_EN
  output logic             sq_out,
`endif
  output logic             tick,
  output logic             busy
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] eff_div;
  ch_state_t        st_q, st_d;
  logic             tick_d;
  logic             busy_d;
  logic             wrap;
  logic             sq_q, sq_d;

  // A zero divisor behaves as divide-by-one
  assign eff_div = (div_q == '0) ? ONE : div_q;
  assign wrap    = st_q.armed && ch_en && (cnt_q == (eff_div - ONE));

  always_comb begin
    div_d  = div_q;
    cnt_d  = cnt_q;
    st_d   = st_q;
    tick_d = 1'b0;
    sq_d   = sq_q;
    // Load wins over a coincident wrap, so no tick is emitted on the load cycle
    if (load) begin
      div_d      = divisor;
      st_d.mode  = oneshot ? MODE_ONESHOT : MODE_PERIODIC;
      st_d.armed = 1'b1;
      cnt_d      = '0;
      sq_d       = 1'b0;
    end else if (st_q.armed && ch_en) begin
      if (wrap) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        sq_d   = ~sq_q;
        if (st_q.mode == MODE_ONESHOT) begin
          st_d.armed = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end
    busy_d = st_d.armed & ch_en;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_q <= DEFAULT_DIV;
      cnt_q <= '0;
      st_q  <= CH_STATE_RST;
      tick  <= 1'b0;
      busy  <= 1'b0;
      sq_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
      st_q  <= st_d;
      tick  <= tick_d;
      busy  <= busy_d;
      sq_q  <= sq_d;
    end
  end

`ifdef MULTI_TICK_GEN_SQ_EN
  assign sq_out = sq_q;
`endif

endmodule

// File: rtl/multi_tick_gen.sv
// rtl/multi_tick_gen.sv - NUM_CH independent tick generators; MULTI_TICK_GEN_SQ_EN adds sq_out
module multi_tick_gen
  import tick_gen_pkg::*;
#(
  parameter int unsigned      NUM_CH      = 4,
  parameter int unsigned      CNT_W       = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(DEFAULT_DIV_DEF)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH-1:0]       load,
  input  logic [NUM_CH*CNT_W-1:0] divisor,
  input  logic [NUM_CH-1:0]       oneshot,
`ifdef MULTI_TICK_GEN_SQ_EN
  output logic [NUM_CH-1:0]       sq_out,
`endif
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       busy
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    tick_gen_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clock   (clock),
      .reset   (reset),
      .ch_en   (ch_en[i]),
      .load    (load[i]),
      .divisor (divisor[i*CNT_W +: CNT_W]),
      .oneshot (oneshot[i]),
`ifdef MULTI_TICK_GEN_SQ_EN
      .sq_out  (sq_out[i]),
`endif
      .tick    (tick[i]),
      .busy    (busy[i])
    );
  end

endmodule
